seq101_rr_scheduler: RTL and testbench



---
 rtl/seq101_rr_scheduler_if.sv | 50 +++++
 rtl/seq101_rr_scheduler.sv | 169 ++++++++++++++++
 tb/tb_seq101_rr_scheduler.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/seq101_rr_scheduler_if.sv
// ---------------------------------------------------------------------------
// seq101_rr_scheduler_if
// Bundles the lane-side and status-side signals of seq101_rr_scheduler.
//   master : front-end / status logic (drives req, bit_in, ch_clr, rd_ch)
//   slave  : the scheduler (drives gnt, det_valid, det_ch, rd_count[, ovf])
// Signals:
//   req[NCH]       per-channel request, bit_in valid
//   bit_in[NCH]    serial data bit per channel
//   ch_clr[NCH]    per-channel synchronous clear
//   gnt[NCH]       one-hot grant (combinational)
//   det_valid      registered "101" detection pulse
//   det_ch[CH_W]   channel of the detection
//   rd_ch[CH_W]    counter readback select
//   rd_count[CNT_W] hit counter of rd_ch
//   ovf[NCH]       sticky overflow flags (only with SEQ101_SCHED_OVF_EN)
// ---------------------------------------------------------------------------
interface seq101_rr_scheduler_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
);
    localparam int CH_W = $clog2(NCH);

    logic [NCH-1:0]   req;
    logic [NCH-1:0]   bit_in;
    logic [NCH-1:0]   ch_clr;
    logic [NCH-1:0]   gnt;
    logic             det_valid;
    logic [CH_W-1:0]  det_ch;
    logic [CH_W-1:0]  rd_ch;
    logic [CNT_W-1:0] rd_count;
`ifdef SEQ101_SCHED_OVF_EN
    logic [NCH-1:0]   ovf;
`endif

    modport master (
        output req, bit_in, ch_clr, rd_ch,
        input  gnt, det_valid, det_ch, rd_count
`ifdef SEQ101_SCHED_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  req, bit_in, ch_clr, rd_ch,
        output gnt, det_valid, det_ch, rd_count
`ifdef SEQ101_SCHED_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/seq101_rr_scheduler.sv
// ---------------------------------------------------------------------------
// seq101_rr_scheduler
// One overlapping "101" Mealy detector core shared round-robin across NCH
// serial channels. Each channel keeps its own 2-bit detector state and a
// saturating hit counter; the granted channel's bit advances its state.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    seq101_rr_scheduler_if.slave (req, bit_in, ch_clr, gnt,
//          det_valid, det_ch, rd_ch, rd_count, optional ovf)
//
// Optional feature macro: SEQ101_SCHED_OVF_EN
//   defined   -> bus.ovf[i] sticky flag, set by a hit on a saturated counter
//   undefined -> no ovf port or logic; counters still saturate
//
// Per-channel detector states:
//   state | meaning
//   S0    | nothing useful seen
//   S1    | last bit was 1
//   S2    | last two bits were 1,0 (a 1 now completes "101")
// ---------------------------------------------------------------------------
module seq101_rr_scheduler #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
) (
    input logic                  clk,
    input logic                  reset,
    seq101_rr_scheduler_if.slave bus
);
    localparam int CH_W = $clog2(NCH);

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10
    } state_t;

    state_t           st  [NCH];
    logic [CNT_W-1:0] cnt [NCH];
    logic [CH_W-1:0]  rr_ptr;

    logic [NCH-1:0]   elig;
    logic [2*NCH-1:0] elig_rot2;
    logic             any_gnt;
    logic [CH_W-1:0]  gnt_idx;

    state_t           cur_st;
    state_t           nxt_st;
    logic             cur_bit;
    logic             hit;
    logic             cnt_sat;

    logic             det_valid_q;
    logic [CH_W-1:0]  det_ch_q;

    // Arbiter: rotate eligibility so bit 0 is the channel after rr_ptr,
    // then take the lowest set bit and map it back to a channel index.
    always_comb begin
        elig      = bus.req & ~bus.ch_clr;
        elig_rot2 = {elig, elig} >> (int'(rr_ptr) + 1);
        any_gnt   = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!any_gnt && elig_rot2[k]) begin
                any_gnt = 1'b1;
                gnt_idx = CH_W'((int'(rr_ptr) + 1 + k) % NCH);
            end
        end
        if (reset) begin
            any_gnt = 1'b0;
        end
    end

    assign bus.gnt = any_gnt ? (NCH'(1) << gnt_idx) : '0;

    // Shared detector core, evaluated on the granted channel's saved state.
    always_comb begin
        cur_st  = st[gnt_idx];
        cur_bit = bus.bit_in[gnt_idx];
        nxt_st  = S0;
        hit     = 1'b0;
        case (cur_st)
            S0: nxt_st = cur_bit ? S1 : S0;
            S1: nxt_st = cur_bit ? S1 : S2;
            S2: begin
                if (cur_bit) begin
                    nxt_st = S1;
                    hit    = 1'b1;
                end else begin
                    nxt_st = S0;
                end
            end
            default: nxt_st = S0;
        endcase
    end

    assign cnt_sat = &cnt[gnt_idx];

    // A granted channel is never being cleared (clear removes eligibility),
    // so the clear loop and the granted-channel update never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                st[i]  <= S0;
                cnt[i] <= '0;
            end
            rr_ptr      <= CH_W'(NCH - 1);
            det_valid_q <= 1'b0;
            det_ch_q    <= '0;
        end else begin
            det_valid_q <= any_gnt && hit;
            for (int i = 0; i < NCH; i++) begin
                if (bus.ch_clr[i]) begin
                    st[i]  <= S0;
                    cnt[i] <= '0;
                end
            end
            if (any_gnt) begin
                rr_ptr      <= gnt_idx;
                st[gnt_idx] <= nxt_st;
                if (hit) begin
                    det_ch_q <= gnt_idx;
                    if (!cnt_sat) begin
                        cnt[gnt_idx] <= cnt[gnt_idx] + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign bus.det_valid = det_valid_q;
    assign bus.det_ch    = det_ch_q;

`ifdef SEQ101_SCHED_OVF_EN
    logic [NCH-1:0] ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (bus.ch_clr[i]) begin
                    ovf_q[i] <= 1'b0;
                end
            end
            if (any_gnt && hit && cnt_sat) begin
                ovf_q[gnt_idx] <= 1'b1;
            end
        end
    end

    assign bus.ovf = ovf_q;
`endif

    // Readback table padded to a power of two so any rd_ch value is safe.
    logic [CNT_W-1:0] rd_tab [2**CH_W];

    for (genvar g = 0; g < 2**CH_W; g++) begin : g_rd
        if (g < NCH) begin : g_real
            assign rd_tab[g] = cnt[g];
        end else begin : g_pad
            assign rd_tab[g] = '0;
        end
    end

    assign bus.rd_count = rd_tab[bus.rd_ch];

endmodule

// File: tb/tb_seq101_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_seq101_rr_scheduler
// Directed, table-driven bench for seq101_rr_scheduler (NCH=4, CNT_W=2).
// Each row: inputs for one cycle, the expected combinational grant in that
// cycle, and the expected registered outputs after the following edge.
// Define SEQ101_SCHED_OVF_EN to also check the sticky overflow flags.
// ---------------------------------------------------------------------------
module tb_seq101_rr_scheduler;
    localparam int NCH   = 4;
    localparam int CNT_W = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    seq101_rr_scheduler_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

    seq101_rr_scheduler #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] bits;
        logic [3:0] clr;
        logic [1:0] rd;
        logic [3:0] gnt;
        logic       dv;
        logic [1:0] dch;
        logic [1:0] cnt;
        logic [3:0] ovf;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void add(input logic rst, input logic [3:0] req, input logic [3:0] bits,
                                input logic [3:0] clr, input logic [1:0] rd, input logic [3:0] gnt,
                                input logic dv, input logic [1:0] dch, input logic [1:0] cnt,
                                input logic [3:0] ovf);
        vec_t v;
        v.rst = rst; v.req = req; v.bits = bits; v.clr = clr; v.rd = rd;
        v.gnt = gnt; v.dv = dv; v.dch = dch; v.cnt = cnt; v.ovf = ovf;
        vecs.push_back(v);
    endfunction

    initial begin
        vec_t v;

        //  rst req      bits     clr      rd  gnt      dv dch cnt ovf
        // ch0 "101"
        add(0, 4'b0001, 4'b0001, 4'b0000, 0, 4'b0001, 0, 0, 0, 4'b0000);
        add(0, 4'b0001, 4'b0000, 4'b0000, 0, 4'b0001, 0, 0, 0, 4'b0000);
        add(0, 4'b0001, 4'b0001, 4'b0000, 0, 4'b0001, 1, 0, 1, 4'b0000);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 1, 4'b0000);
        // ch2 overlap 1,0,1,0,1 then 0,1 proves it ended in S1
        add(0, 4'b0100, 4'b0100, 4'b0000, 2, 4'b0100, 0, 0, 0, 4'b0000);
        add(0, 4'b0100, 4'b0000, 4'b0000, 2, 4'b0100, 0, 0, 0, 4'b0000);
        add(0, 4'b0100, 4'b0100, 4'b0000, 2, 4'b0100, 1, 2, 1, 4'b0000);
        add(0, 4'b0100, 4'b0000, 4'b0000, 2, 4'b0100, 0, 0, 1, 4'b0000);
        add(0, 4'b0100, 4'b0100, 4'b0000, 2, 4'b0100, 1, 2, 2, 4'b0000);
        add(0, 4'b0100, 4'b0000, 4'b0000, 2, 4'b0100, 0, 0, 2, 4'b0000);
        add(0, 4'b0100, 4'b0100, 4'b0000, 2, 4'b0100, 1, 2, 3, 4'b0000);
        // reset with all requesting: no grant, counters cleared
        add(1, 4'b1111, 4'b0000, 4'b0000, 2, 4'b0000, 0, 0, 0, 4'b0000);
        // fairness
        for (int r = 0; r < 2; r++) begin
            add(0, 4'b1111, 4'b0000, 4'b0000, 0, 4'b0001, 0, 0, 0, 4'b0000);
            add(0, 4'b1111, 4'b0000, 4'b0000, 0, 4'b0010, 0, 0, 0, 4'b0000);
            add(0, 4'b1111, 4'b0000, 4'b0000, 0, 4'b0100, 0, 0, 0, 4'b0000);
            add(0, 4'b1111, 4'b0000, 4'b0000, 0, 4'b1000, 0, 0, 0, 4'b0000);
        end
        // interleaved ch1 (1,0,1) and ch3 (0,0,0), bits held until granted
        add(0, 4'b1010, 4'b0010, 4'b0000, 1, 4'b0010, 0, 0, 0, 4'b0000);
        add(0, 4'b1010, 4'b0000, 4'b0000, 1, 4'b1000, 0, 0, 0, 4'b0000);
        add(0, 4'b1010, 4'b0000, 4'b0000, 1, 4'b0010, 0, 0, 0, 4'b0000);
        add(0, 4'b1010, 4'b0010, 4'b0000, 1, 4'b1000, 0, 0, 0, 4'b0000);
        add(0, 4'b1010, 4'b0010, 4'b0000, 1, 4'b0010, 1, 1, 1, 4'b0000);
        add(0, 4'b1000, 4'b0000, 4'b0000, 1, 4'b1000, 0, 0, 1, 4'b0000);
        // clear collision: ch0 to S2 with count 1, ch1 to S2
        add(0, 4'b0001, 4'b0001, 4'b0000, 0, 4'b0001, 0, 0, 0, 4'b0000);
        add(0, 4'b0001, 4'b0000, 4'b0000, 0, 4'b0001, 0, 0, 0, 4'b0000);
        add(0, 4'b0001, 4'b0001, 4'b0000, 0, 4'b0001, 1, 0, 1, 4'b0000);
        add(0, 4'b0001, 4'b0000, 4'b0000, 0, 4'b0001, 0, 0, 1, 4'b0000);
        add(0, 4'b0010, 4'b0000, 4'b0000, 0, 4'b0010, 0, 0, 1, 4'b0000);
        add(0, 4'b0011, 4'b0011, 4'b0001, 0, 4'b0010, 1, 1, 0, 4'b0000);
        add(0, 4'b0001, 4'b0001, 4'b0000, 1, 4'b0001, 0, 0, 2, 4'b0000);
        add(0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 2, 4'b0000);
        // saturation on ch0 (starts in S1, count 0)
        add(0, 4'b0001, 4'b0000, 4'b0000, 0, 4'b0001, 0, 0, 0, 4'b0000);
        add(0, 4'b0001, 4'b0001, 4'b0000, 0, 4'b0001, 1, 0, 1, 4'b0000);
        add(0, 4'b0001, 4'b0000, 4'b0000, 0, 4'b0001, 0, 0, 1, 4'b0000);
        add(0, 4'b0001, 4'b0001, 4'b0000, 0, 4'b0001, 1, 0, 2, 4'b0000);
        add(0, 4'b0001, 4'b0000, 4'b0000, 0, 4'b0001, 0, 0, 2, 4'b0000);
        add(0, 4'b0001, 4'b0001, 4'b0000, 0, 4'b0001, 1, 0, 3, 4'b0000);
        add(0, 4'b0001, 4'b0000, 4'b0000, 0, 4'b0001, 0, 0, 3, 4'b0000);
        add(0, 4'b0001, 4'b0001, 4'b0000, 0, 4'b0001, 1, 0, 3, 4'b0001);
        add(0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 3, 4'b0001);
        add(0, 4'b0000, 4'b0000, 4'b0001, 0, 4'b0000, 0, 0, 0, 4'b0000);
        // reset mid-stream with ch0 in S2
        add(0, 4'b0001, 4'b0001, 4'b0000, 1, 4'b0001, 0, 0, 2, 4'b0000);
        add(0, 4'b0001, 4'b0000, 4'b0000, 1, 4'b0001, 0, 0, 2, 4'b0000);
        add(1, 4'b0001, 4'b0001, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000);
        add(0, 4'b0001, 4'b0001, 4'b0000, 1, 4'b0001, 0, 0, 0, 4'b0000);

        bus.req    = 4'b1111;
        bus.bit_in = 4'b0000;
        bus.ch_clr = 4'b0000;
        bus.rd_ch  = 2'd0;
        reset      = 1'b1;
        #1;
        chk("reset_gnt_comb", 32'(bus.gnt), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_det_valid", 32'(bus.det_valid), 32'h0);
        chk("reset_det_ch", 32'(bus.det_ch), 32'h0);
        chk("reset_rd_count", 32'(bus.rd_count), 32'h0);
        chk("reset_gnt", 32'(bus.gnt), 32'h0);
`ifdef SEQ101_SCHED_OVF_EN
        chk("reset_ovf", 32'(bus.ovf), 32'h0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            reset      = v.rst;
            bus.req    = v.req;
            bus.bit_in = v.bits;
            bus.ch_clr = v.clr;
            bus.rd_ch  = v.rd;
            #1;
            chk($sformatf("row%0d gnt", i), 32'(bus.gnt), 32'(v.gnt));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d det_valid", i), 32'(bus.det_valid), 32'(v.dv));
            if (v.dv)
                chk($sformatf("row%0d det_ch", i), 32'(bus.det_ch), 32'(v.dch));
            chk($sformatf("row%0d rd_count", i), 32'(bus.rd_count), 32'(v.cnt));
`ifdef SEQ101_SCHED_OVF_EN
            chk($sformatf("row%0d ovf", i), 32'(bus.ovf), 32'(v.ovf));
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
